// File: rtl/flg_pkg.sv
// rtl/flg_pkg.sv - shared types and helpers for the flag match enumerator
package flg_pkg;

  localparam int FLG_W_DEFAULT = 32;
  localparam int FLG_W_MAX     = 128;
  localparam int FLG_POS_W_MAX = 7;

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} flg_state_t;

  // Index of the lowest set bit, sized for the widest word; callers truncate.
  function automatic logic [FLG_POS_W_MAX-1:0] lowest_set_idx(input logic [FLG_W_MAX-1:0] vec);
    logic [FLG_POS_W_MAX-1:0] idx;
    idx = '0;
    for (int i = FLG_W_MAX - 1; i >= 0; i--) begin
      if (vec[i]) idx = FLG_POS_W_MAX'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/flg_prefix_count.sv
// rtl/flg_prefix_count.sv - popcount of a flag word strictly below a bit position
module flg_prefix_count
  import flg_pkg::*;
#(
  parameter int FLAG_WIDTH = FLG_W_DEFAULT,
  parameter int POS_W      = $clog2(FLAG_WIDTH)
) (
  input  logic [FLAG_WIDTH-1:0] flg,
  input  logic [POS_W-1:0]      pos,
  output logic [POS_W-1:0]      cnt
);

  logic [FLAG_WIDTH-1:0] mask;
  // Heap-ordered adder tree: leaves at FLAG_WIDTH-1.., root at 0. Every node
  // fits POS_W bits since the top flag bit is never below pos.
  logic [POS_W-1:0]      node [2*FLAG_WIDTH-1];

  for (genvar i = 0; i < FLAG_WIDTH; i++) begin : g_leaf
    assign mask[i]                = (pos > POS_W'(i));
    assign node[FLAG_WIDTH-1 + i] = POS_W'(flg[i] & mask[i]);
  end

  for (genvar j = 0; j < FLAG_WIDTH - 1; j++) begin : g_tree
    assign node[j] = node[2*j+1] + node[2*j+2];
  end

  assign cnt = node[0];

endmodule

// File: rtl/flg_match_iter.sv
// rtl/flg_match_iter.sv - enumerates matching act/wei flag positions with buffer offsets
module flg_match_iter
  import flg_pkg::*;
#(
  parameter int FLAG_WIDTH = FLG_W_DEFAULT,
  parameter int POS_W      = $clog2(FLAG_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FLAG_WIDTH-1:0] in_act_flg,
  input  logic [FLAG_WIDTH-1:0] in_wei_flg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [POS_W-1:0]      out_pos,
  output logic [POS_W-1:0]      out_act_ofs,
  output logic [POS_W-1:0]      out_wei_ofs,
  output logic [POS_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  out_none
);

  flg_state_t            state, state_n;
  logic [FLAG_WIDTH-1:0] act_r, wei_r, rem_r;
  logic [POS_W-1:0]      idx_r;
  logic                  none_r;

  logic                  scan, single, last, beat, accept;
  logic [POS_W-1:0]      pos, act_ofs, wei_ofs;

  assign scan   = (state == SCAN);
  assign pos    = POS_W'(lowest_set_idx(FLG_W_MAX'(rem_r)));
  assign single = (rem_r != '0) && ((rem_r & (rem_r - FLAG_WIDTH'(1))) == '0);
  assign last   = scan & (none_r | single);
  assign beat   = scan & out_ready;

  // Flush outranks both the closing beat and any reload in the same cycle.
  assign in_ready = (~scan | (beat & last)) & ~flush;
  assign accept   = in_valid & in_ready;

  flg_prefix_count #(.FLAG_WIDTH(FLAG_WIDTH), .POS_W(POS_W)) u_act_cnt (
    .flg (act_r),
    .pos (pos),
    .cnt (act_ofs)
  );

  flg_prefix_count #(.FLAG_WIDTH(FLAG_WIDTH), .POS_W(POS_W)) u_wei_cnt (
    .flg (wei_r),
    .pos (pos),
    .cnt (wei_ofs)
  );

  assign out_valid   = scan;
  assign out_pos     = scan ? pos     : '0;
  assign out_act_ofs = scan ? act_ofs : '0;
  assign out_wei_ofs = scan ? wei_ofs : '0;
  assign out_idx     = scan ? idx_r   : '0;
  assign out_last    = last;
  assign out_none    = scan & none_r;

  always_comb begin
    state_n = state;
    if (flush)               state_n = IDLE;
    else if (accept)         state_n = SCAN;
    else if (beat && last)   state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_r  <= '0;
      wei_r  <= '0;
      rem_r  <= '0;
      idx_r  <= '0;
      none_r <= 1'b0;
    end else if (flush) begin
      rem_r  <= '0;
      idx_r  <= '0;
      none_r <= 1'b0;
    end else if (accept) begin
      act_r  <= in_act_flg;
      wei_r  <= in_wei_flg;
      rem_r  <= in_act_flg & in_wei_flg;
      idx_r  <= '0;
      none_r <= ((in_act_flg & in_wei_flg) == '0);
    end else if (beat) begin
      rem_r  <= rem_r & (rem_r - FLAG_WIDTH'(1));
      idx_r  <= idx_r + POS_W'(1);
      none_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flg_match_iter.sv
// tb/tb_flg_match_iter.sv - scoreboard bench for flg_match_iter
module tb_flg_match_iter;

  localparam int W  = 32;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_act_flg = '0;
  logic [W-1:0]  in_wei_flg = '0;
  logic          in_ready, out_valid, out_last, out_none;
  logic [PW-1:0] out_pos, out_act_ofs, out_wei_ofs, out_idx;

  typedef struct packed {
    logic [PW-1:0] pos;
    logic [PW-1:0] aofs;
    logic [PW-1:0] wofs;
    logic [PW-1:0] idx;
    logic          last;
    logic          none;
  } beat_t;

  typedef struct packed {
    logic [W-1:0] act;
    logic [W-1:0] wei;
  } word_t;

  beat_t exp_q[$];
  word_t in_q[$];
  beat_t obs;
  beat_t held;
  int    n_cmp = 0;
  int    n_fail = 0;

  assign obs = {out_pos, out_act_ofs, out_wei_ofs, out_idx, out_last, out_none};

  flg_match_iter #(.FLAG_WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_act_flg  (in_act_flg),
    .in_wei_flg  (in_wei_flg),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pos     (out_pos),
    .out_act_ofs (out_act_ofs),
    .out_wei_ofs (out_wei_ofs),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .out_none    (out_none)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got time %0t, required < 500000", $time);
    $fatal(1);
  end

  // Reference enumeration straight from the definition of the offsets.
  task automatic push_expect(input logic [W-1:0] act, input logic [W-1:0] wei);
    logic [W-1:0] rem, below;
    beat_t        b;
    int           k;
    rem = act & wei;
    k   = 0;
    if (rem == '0) begin
      b      = '0;
      b.last = 1'b1;
      b.none = 1'b1;
      exp_q.push_back(b);
    end
    for (int p = 0; p < W; p++) begin
      if (rem[p]) begin
        below  = (32'h1 << p) - 32'h1;
        b.pos  = PW'(p);
        b.aofs = PW'($countones(act & below));
        b.wofs = PW'($countones(wei & below));
        b.idx  = PW'(k);
        b.last = ((rem >> p) == 32'h1);
        b.none = 1'b0;
        exp_q.push_back(b);
        k++;
      end
    end
  endtask

  // Streams in_q through the DUT with out_ready high, popping and comparing every beat.
  task automatic pump(input int budget, input string tag);
    int    cyc;
    word_t w;
    beat_t e;
    cyc = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (in_q.size() > 0) begin
        in_valid   = 1'b1;
        in_act_flg = in_q[0].act;
        in_wei_flg = in_q[0].wei;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_cmp++;
      if (out_valid !== (exp_q.size() > 0)) begin
        n_fail++;
        $display("FAIL %s valid cyc%0d: got out_valid=%b, required %b", tag, cyc, out_valid, exp_q.size() > 0);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL %s beat: got pos=%0d aofs=%0d wofs=%0d idx=%0d last=%b none=%b, required pos=%0d aofs=%0d wofs=%0d idx=%0d last=%b none=%b",
                   tag, obs.pos, obs.aofs, obs.wofs, obs.idx, obs.last, obs.none,
                   e.pos, e.aofs, e.wofs, e.idx, e.last, e.none);
        end
      end
      if (in_valid && in_ready) begin
        w = in_q.pop_front();
        push_expect(w.act, w.wei);
      end
      cyc++;
    end
    if (in_q.size() > 0 || exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s timeout: got %0d words and %0d beats pending, required 0", tag, in_q.size(), exp_q.size());
      in_q.delete();
      exp_q.delete();
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || obs !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b fields=%h, required 1 0 0", in_ready, out_valid, obs);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_words();
    in_q.push_back('{act: 32'h000000F0, wei: 32'h00000030});
    pump(20, "case1");
    in_q.push_back('{act: 32'hFFFFFFFF, wei: 32'h80000001});
    pump(20, "case2");
    in_q.push_back('{act: 32'h0000000F, wei: 32'h000000F0});
    pump(20, "zero_match");
    in_q.push_back('{act: 32'hA5A5F00F, wei: 32'h3C3CFF11});
    pump(40, "mixed");
  endtask

  task automatic test_backpressure();
    beat_t e;
    @(negedge clk);
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_act_flg = 32'h000000F0;
    in_wei_flg = 32'h00000030;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept: got in_ready=%b, required 1", in_ready);
    end
    push_expect(in_act_flg, in_wei_flg);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || obs !== e) begin
      n_fail++;
      $display("FAIL bp_first: got valid=%b fields=%h, required 1 %h", out_valid, obs, e);
    end
    held = exp_q[0];
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || obs !== held || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got valid=%b fields=%h in_ready=%b, required 1 %h 0", s, out_valid, obs, in_ready, held);
      end
    end
    pump(10, "bp_release");
    in_q.push_back('{act: 32'h000000F0, wei: 32'h00000030});
    in_q.push_back('{act: 32'hFFFFFFFF, wei: 32'h80000001});
    in_q.push_back('{act: 32'h0000000F, wei: 32'h000000F0});
    in_q.push_back('{act: 32'h00000003, wei: 32'h00000001});
    pump(40, "back_to_back");
  endtask

  task automatic test_flush();
    beat_t e;
    @(negedge clk);
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_act_flg = 32'hFFFFFFFF;
    in_wei_flg = 32'hFFFFFFFF;
    #1;
    push_expect(in_act_flg, in_wei_flg);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || obs !== e) begin
      n_fail++;
      $display("FAIL flush_beat0: got valid=%b fields=%h, required 1 %h", out_valid, obs, e);
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== 5'd1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cycle: got valid=%b idx=%0d in_ready=%b, required 1 1 0", out_valid, out_idx, in_ready);
    end
    exp_q.delete();
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_after: got valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    in_q.push_back('{act: 32'h000000F0, wei: 32'h00000030});
    pump(20, "post_flush");
  endtask

  task automatic test_reset_mid_word();
    beat_t e;
    @(negedge clk);
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_act_flg = 32'hFFFFFFFF;
    in_wei_flg = 32'h0F0F0F0F;
    #1;
    push_expect(in_act_flg, in_wei_flg);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || obs !== e) begin
      n_fail++;
      $display("FAIL rst_beat0: got valid=%b fields=%h, required 1 %h", out_valid, obs, e);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== '0) begin
      n_fail++;
      $display("FAIL rst_async: got valid=%b in_ready=%b fields=%h, required 0 1 0", out_valid, in_ready, obs);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_stale%0d: got out_valid=%b, required 0", c, out_valid);
      end
    end
    in_q.push_back('{act: 32'hFFFFFFFF, wei: 32'h80000001});
    pump(20, "post_reset");
  endtask

  initial begin
    test_reset();
    test_words();
    test_backpressure();
    test_flush();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
